// File: rtl/invntt_feeder.sv
// Coefficient buffer feeding invntt: host-loaded 2^DEPTH x 16 store, streamed out as
// even/odd coefficient pairs under readin_ok flow control.
module invntt_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned Q     = 3329
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [DEPTH-1:0] wr_addr,
  input  logic [15:0]      wr_data,
  input  logic             start,
  input  logic             readin_ok,
  output logic             readin,
  output logic [15:0]      invntt_din_1,
  output logic [15:0]      invntt_din_2,
  output logic [DEPTH-1:0] in_index,
  output logic             full_in,
  output logic             busy,
  output logic             done,
  output logic             range_err
);

  localparam int unsigned N = 1 << DEPTH;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [15:0]      r_mem [N];
  logic [DEPTH-1:0] r_index;
  logic             r_range_err;
  logic [DEPTH-1:0] w_index_hi;
  logic             w_last;
  logic             w_beat;
  logic             w_write;

  assign w_last     = (r_index == DEPTH'(N - 2));
  assign w_beat     = (r_state == StStream) && readin_ok;
  // Reset blocks the host write so a reset cycle has no side effects on the buffer.
  assign w_write    = !reset && (r_state == StIdle) && wr_en;
  assign w_index_hi = r_index + DEPTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (start) w_state_next = StStream;
      StStream: if (w_beat && w_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    readin  = (r_state == StStream);
    busy    = (r_state == StStream);
    done    = (r_state == StDone);
    full_in = (r_state == StStream) && w_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index <= '0;
    end else if (w_beat) begin
      r_index <= w_last ? '0 : r_index + DEPTH'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_range_err <= 1'b0;
    end else if (w_write && (wr_data >= 16'(Q))) begin
      r_range_err <= 1'b1;
    end
  end

  assign invntt_din_1 = r_mem[w_index_hi];
  assign invntt_din_2 = r_mem[r_index];
  assign in_index     = r_index;
  assign range_err    = r_range_err;

endmodule
